// File: rtl/hex_entry_encoder.sv
// Hex keypad entry encoder: accumulates hex digits MSD-first into a binary
// value, with backspace, clear and commit, feeding the calculator datapath.
module hex_entry_encoder #(
  parameter int MAX_DIGITS = 8,
  localparam int W = 4 * MAX_DIGITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_digit_stb,
  input  logic [3:0]   key_digit,
  input  logic         key_back_stb,
  input  logic         key_clear_stb,
  input  logic         key_enter_stb,
  output logic [W-1:0] entry_value,
  output logic [3:0]   digit_count,
  output logic [W-1:0] committed_value,
  output logic         commit_valid,
  output logic         committed,
  output logic         overflow
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ENTRY     = 2'd1,
    COMMITTED = 2'd2
  } state_e;

  localparam logic [3:0] FULL_COUNT = 4'(MAX_DIGITS);

  state_e         state_q, state_d;
  logic [W-1:0]   entry_q, entry_d;
  logic [3:0]     count_q, count_d;
  logic [W-1:0]   commit_val_q, commit_val_d;
  logic           commit_valid_q, commit_valid_d;
  logic           overflow_q, overflow_d;

  // NOTE: every signal gets a default before the case logic so partial
  // assignment paths cannot infer latches.
  always_comb begin
    state_d        = state_q;
    entry_d        = entry_q;
    count_d        = count_q;
    commit_val_d   = commit_val_q;
    commit_valid_d = 1'b0;
    overflow_d     = 1'b0;

    // Priority chain: only the highest-priority strobe acts.
    if (key_clear_stb) begin
      entry_d = '0;
      count_d = '0;
      state_d = EMPTY;
    end else if (key_enter_stb) begin
      if (state_q != COMMITTED) begin
        commit_val_d   = entry_q;
        commit_valid_d = 1'b1;
        state_d        = COMMITTED;
      end
    end else if (key_back_stb) begin
      if (state_q == ENTRY) begin
        entry_d = entry_q >> 4;
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) state_d = EMPTY;
      end
    end else if (key_digit_stb) begin
      if (state_q == ENTRY) begin
        if (count_q == FULL_COUNT) begin
          overflow_d = 1'b1;
        end else begin
          entry_d = (entry_q << 4) | W'(key_digit);
          count_d = count_q + 4'd1;
        end
      end else if (key_digit == 4'h0) begin
        // Leading zero is never counted; a fresh entry after commit starts empty.
        entry_d = '0;
        count_d = '0;
        state_d = EMPTY;
      end else begin
        entry_d = W'(key_digit);
        count_d = 4'd1;
        state_d = ENTRY;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= EMPTY;
      entry_q        <= '0;
      count_q        <= '0;
      commit_val_q   <= '0;
      commit_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      entry_q        <= entry_d;
      count_q        <= count_d;
      commit_val_q   <= commit_val_d;
      commit_valid_q <= commit_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign entry_value     = entry_q;
  assign digit_count     = count_q;
  assign committed_value = commit_val_q;
  assign commit_valid    = commit_valid_q;
  assign committed       = (state_q == COMMITTED);
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_hex_entry_encoder.sv
// Directed self-checking bench for hex_entry_encoder (MAX_DIGITS=8).
module tb_hex_entry_encoder;

  logic        clk;
  logic        reset;
  logic        key_digit_stb;
  logic [3:0]  key_digit;
  logic        key_back_stb;
  logic        key_clear_stb;
  logic        key_enter_stb;
  logic [31:0] entry_value;
  logic [3:0]  digit_count;
  logic [31:0] committed_value;
  logic        commit_valid;
  logic        committed;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  hex_entry_encoder #(.MAX_DIGITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .key_digit_stb  (key_digit_stb),
    .key_digit      (key_digit),
    .key_back_stb   (key_back_stb),
    .key_clear_stb  (key_clear_stb),
    .key_enter_stb  (key_enter_stb),
    .entry_value    (entry_value),
    .digit_count    (digit_count),
    .committed_value(committed_value),
    .commit_valid   (commit_valid),
    .committed      (committed),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let one rising edge pass, then release strobes.
  // Outputs are sampled 1 time unit after the edge.
  task automatic apply(input logic rst, input logic dstb, input logic [3:0] d,
                       input logic back, input logic clr, input logic ent);
    reset = rst; key_digit_stb = dstb; key_digit = d;
    key_back_stb = back; key_clear_stb = clr; key_enter_stb = ent;
    @(posedge clk); #1;
    reset = 1'b0; key_digit_stb = 1'b0; key_digit = 4'h0;
    key_back_stb = 1'b0; key_clear_stb = 1'b0; key_enter_stb = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d);
    apply(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic back();  apply(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0); endtask
  task automatic clear(); apply(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0); endtask
  task automatic enter(); apply(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1); endtask
  task automatic idle();  apply(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (entry_value !== 32'h0) begin errors++; $display("FAIL reset_entry got=%h want=0", entry_value); end
    checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", digit_count); end
    checks++; if (committed_value !== 32'h0) begin errors++; $display("FAIL reset_cval got=%h want=0", committed_value); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_cvalid got=%b want=0", commit_valid); end
    checks++; if (committed !== 1'b0) begin errors++; $display("FAIL reset_committed got=%b want=0", committed); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_digits();
    logic [3:0]  seq [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [31:0] exp_v [4] = '{32'h1, 32'h12, 32'h123, 32'h1234};
    for (int i = 0; i < 4; i++) begin
      digit(seq[i]);
      checks++; if (entry_value !== exp_v[i]) begin errors++; $display("FAIL dig_entry[%0d] got=%h want=%h", i, entry_value, exp_v[i]); end
      checks++; if (digit_count !== 4'(i + 1)) begin errors++; $display("FAIL dig_count[%0d] got=%0d want=%0d", i, digit_count, i + 1); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dig_overflow[%0d] got=%b want=0", i, overflow); end
    end
    checks++; if (committed !== 1'b0) begin errors++; $display("FAIL dig_committed got=%b want=0", committed); end
  endtask

  task automatic test_leading_zero_commit();
    clear();
    digit(4'h0);
    digit(4'h0);
    checks++; if (digit_count !== 4'd0 || entry_value !== 32'h0) begin errors++; $display("FAIL lz_zeros got=%h/%0d want=0/0", entry_value, digit_count); end
    digit(4'h5);
    checks++; if (entry_value !== 32'h5 || digit_count !== 4'd1) begin errors++; $display("FAIL lz_five got=%h/%0d want=5/1", entry_value, digit_count); end
    enter();
    checks++; if (committed_value !== 32'h5) begin errors++; $display("FAIL commit_val got=%h want=5", committed_value); end
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL commit_pulse got=%b want=1", commit_valid); end
    checks++; if (committed !== 1'b1) begin errors++; $display("FAIL commit_state got=%b want=1", committed); end
    checks++; if (entry_value !== 32'h5 || digit_count !== 4'd1) begin errors++; $display("FAIL commit_hold got=%h/%0d want=5/1", entry_value, digit_count); end
    idle();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL commit_pulse_end got=%b want=0", commit_valid); end
    enter();
    checks++; if (commit_valid !== 1'b0 || committed !== 1'b1) begin errors++; $display("FAIL recommit got=%b/%b want=0/1", commit_valid, committed); end
    back();
    checks++; if (entry_value !== 32'h5 || committed !== 1'b1) begin errors++; $display("FAIL commit_back got=%h/%b want=5/1", entry_value, committed); end
  endtask

  task automatic test_overflow();
    logic [3:0] seq [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
    clear();
    foreach (seq[i]) digit(seq[i]);
    checks++; if (entry_value !== 32'hABCDEF12 || digit_count !== 4'd8) begin errors++; $display("FAIL ovf_full got=%h/%0d want=abcdef12/8", entry_value, digit_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b want=0", overflow); end
    digit(4'h3);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
    checks++; if (entry_value !== 32'hABCDEF12 || digit_count !== 4'd8) begin errors++; $display("FAIL ovf_hold got=%h/%0d want=abcdef12/8", entry_value, digit_count); end
    idle();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got=%b want=0", overflow); end
    checks++; if (committed_value !== 32'h5) begin errors++; $display("FAIL ovf_cval got=%h want=5", committed_value); end
  endtask

  task automatic test_backspace();
    logic [31:0] exp_v [4] = '{32'h12, 32'h1, 32'h0, 32'h0};
    logic [3:0]  exp_c [4] = '{4'd2, 4'd1, 4'd0, 4'd0};
    clear();
    digit(4'h1); digit(4'h2); digit(4'h3);
    for (int i = 0; i < 4; i++) begin
      back();
      checks++; if (entry_value !== exp_v[i] || digit_count !== exp_c[i]) begin errors++; $display("FAIL back[%0d] got=%h/%0d want=%h/%0d", i, entry_value, digit_count, exp_v[i], exp_c[i]); end
    end
    // Back in EMPTY: a leading zero must still be ignored.
    digit(4'h0);
    checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL back_empty got=%0d want=0", digit_count); end
  endtask

  task automatic test_priority();
    clear();
    digit(4'h7); digit(4'h7);
    apply(1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1);
    checks++; if (entry_value !== 32'h0 || digit_count !== 4'd0) begin errors++; $display("FAIL prio_clear got=%h/%0d want=0/0", entry_value, digit_count); end
    checks++; if (commit_valid !== 1'b0 || committed_value !== 32'h5) begin errors++; $display("FAIL prio_noenter got=%b/%h want=0/5", commit_valid, committed_value); end
    digit(4'h1); digit(4'h2);
    apply(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    checks++; if (entry_value !== 32'h1 || digit_count !== 4'd1) begin errors++; $display("FAIL prio_back got=%h/%0d want=1/1", entry_value, digit_count); end
  endtask

  task automatic test_commit_empty();
    clear();
    enter();
    checks++; if (commit_valid !== 1'b1 || committed !== 1'b1 || committed_value !== 32'h0) begin errors++; $display("FAIL empty_commit got=%b/%b/%h want=1/1/0", commit_valid, committed, committed_value); end
    digit(4'h0);
    checks++; if (committed !== 1'b0 || digit_count !== 4'd0 || entry_value !== 32'h0) begin errors++; $display("FAIL committed_zero got=%b/%0d/%h want=0/0/0", committed, digit_count, entry_value); end
  endtask

  task automatic test_back_to_back();
    digit(4'h5);
    enter();
    digit(4'h9);
    checks++; if (entry_value !== 32'h9 || digit_count !== 4'd1) begin errors++; $display("FAIL restart got=%h/%0d want=9/1", entry_value, digit_count); end
    checks++; if (committed !== 1'b0 || committed_value !== 32'h5) begin errors++; $display("FAIL restart_cval got=%b/%h want=0/5", committed, committed_value); end
    digit(4'h8);
    checks++; if (entry_value !== 32'h98 || digit_count !== 4'd2) begin errors++; $display("FAIL restart_more got=%h/%0d want=98/2", entry_value, digit_count); end
    apply(1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
    checks++; if (entry_value !== 32'h0 || digit_count !== 4'd0 || committed_value !== 32'h0) begin errors++; $display("FAIL midreset got=%h/%0d/%h want=0/0/0", entry_value, digit_count, committed_value); end
    checks++; if (commit_valid !== 1'b0 || committed !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b/%b/%b want=0/0/0", commit_valid, committed, overflow); end
  endtask

  initial begin
    reset = 1'b1; key_digit_stb = 1'b0; key_digit = 4'h0;
    key_back_stb = 1'b0; key_clear_stb = 1'b0; key_enter_stb = 1'b0;
    test_reset();
    test_digits();
    test_leading_zero_commit();
    test_overflow();
    test_backspace();
    test_priority();
    test_commit_empty();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
